// File: rtl/bm_bridge_pkg.sv
// bm_bridge_pkg: shared state encoding and constants for the board-manager Wishbone bridge
package bm_bridge_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, ACK = 2'd2} state_t;
  localparam logic [31:0] BM_ERR_DATA = 32'hBADACCE5;
  localparam logic [19:0] BM_STATUS_ADDR = 20'hFFFFF;
endpackage

// File: rtl/bm_bus_bridge.sv
// bm_bus_bridge: board-manager request to Wishbone-classic master with timeout and error count
// Define BM_BRIDGE_STATUS_EN to serve BM_STATUS_ADDR locally (read status, write clears errors).
module bm_bus_bridge
  import bm_bridge_pkg::*;
#(
  parameter int TIMEOUT_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        wr_i,
  input  logic [19:0] adr_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [19:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [7:0]  err_count_o
);
  state_t state;
  logic [TIMEOUT_BITS-1:0] timer;
  logic expired, fail, term;
  logic [7:0] err_next;
`ifdef BM_BRIDGE_STATUS_EN
  logic local_q;
`endif
  // the timer counts bus cycles already spent, so cyc stays high for exactly TIMEOUT_CYCLES
  assign expired  = timer == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  assign fail     = wb_err_i | (expired & ~wb_ack_i);
  assign term     = wb_ack_i | wb_err_i | expired;
  assign err_next = err_count_o == 8'hFF ? 8'hFF : err_count_o + 8'd1;
  assign wb_stb_o = wb_cyc_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      ack_o       <= 1'b0;
      dat_o       <= '0;
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
      err_count_o <= '0;
`ifdef BM_BRIDGE_STATUS_EN
      local_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (en_i) begin
          state    <= BUS;
          timer    <= '0;
          wb_we_o  <= wr_i;
          wb_adr_o <= adr_i;
          wb_sel_o <= wr_i ? wstrb_i : 4'hF;
          wb_dat_o <= dat_i;
`ifdef BM_BRIDGE_STATUS_EN
          local_q  <= adr_i == BM_STATUS_ADDR;
          wb_cyc_o <= adr_i != BM_STATUS_ADDR;
`else
          wb_cyc_o <= 1'b1;
`endif
        end
        BUS: begin
`ifdef BM_BRIDGE_STATUS_EN
          if (local_q) begin
            state <= ACK;
            ack_o <= 1'b1;
            dat_o <= wb_we_o ? 32'h0 : {16'h0, 8'(TIMEOUT_CYCLES), err_count_o};
            if (wb_we_o) err_count_o <= '0;
          end else
`endif
          if (term) begin
            state    <= ACK;
            ack_o    <= 1'b1;
            wb_cyc_o <= 1'b0;
            dat_o    <= fail ? BM_ERR_DATA : (wb_we_o ? 32'h0 : wb_dat_i);
            if (fail) err_count_o <= err_next;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bm_bus_bridge.sv
// tb_bm_bus_bridge: scoreboard bench for bm_bus_bridge; expected read data queued at request time
module tb_bm_bus_bridge;
  localparam int TMO = 200;
  logic clk = 1'b0, rst = 1'b1;
  logic en_i = 0, wr_i = 0, wb_ack_i = 0, wb_err_i = 0;
  logic [19:0] adr_i = '0;
  logic [3:0] wstrb_i = '0;
  logic [31:0] dat_i = '0, wb_dat_i = '0;
  logic ack_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] dat_o, wb_dat_o;
  logic [19:0] wb_adr_o;
  logic [3:0] wb_sel_o;
  logic [7:0] err_count_o;
  int n_checks = 0, n_fails = 0;
  int exp_err = 0;
  logic [31:0] q[$];

  bm_bus_bridge #(.TIMEOUT_BITS(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .wr_i(wr_i), .adr_i(adr_i), .wstrb_i(wstrb_i),
    .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst && ack_o) begin
    if (q.size() == 0) check("spurious_ack", ack_o, 1'b0);
    else check("dat_o", dat_o, q.pop_front());
  end

  // resp: 0 ack, 1 err, 2 ack+err, 3 no response
  task automatic txn(input logic w, input logic [19:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int wait_n, input int resp, input logic [31:0] rd, input logic drop);
    logic fail;
    int cnt;
    fail = resp != 0 || wait_n > TMO - 1;
    q.push_back(fail ? 32'hBADACCE5 : (w ? 32'h0 : rd));
    if (fail) exp_err = exp_err == 255 ? 255 : exp_err + 1;
    en_i = 1; wr_i = w; adr_i = a; wstrb_i = s; dat_i = d;
    @(negedge clk);
    check("cyc_start", wb_cyc_o, 1'b1);
    check("stb_start", wb_stb_o, 1'b1);
    check("we", wb_we_o, w);
    check("sel", wb_sel_o, w ? s : 4'hF);
    check("adr", wb_adr_o, a);
    if (w) check("wdat", wb_dat_o, d);
    if (drop) en_i = 0;
    cnt = 1;
    if (resp != 3 && wait_n < TMO) begin
      repeat (wait_n) @(negedge clk);
      wb_ack_i = resp == 0 || resp == 2;
      wb_err_i = resp != 0;
      wb_dat_i = rd;
      @(negedge clk);
    end else begin
      while (wb_cyc_o && cnt < 2 * TMO) begin
        @(negedge clk);
        if (wb_cyc_o) cnt++;
      end
      check("timeout_cycles", cnt, TMO);
    end
    check("ack_o", ack_o, 1'b1);
    check("cyc_drop", wb_cyc_o, 1'b0);
    check("err_count", err_count_o, exp_err);
    wb_ack_i = 0; wb_err_i = 0; en_i = 0;
    @(negedge clk);
    check("ack_pulse", ack_o, 1'b0);
  endtask

`ifdef BM_BRIDGE_STATUS_EN
  task automatic stat(input logic w);
    q.push_back(w ? 32'h0 : {16'h0, 8'(TMO), 8'(exp_err)});
    en_i = 1; wr_i = w; adr_i = 20'hFFFFF; dat_i = 32'h1;
    @(negedge clk);
    check("stat_no_cyc", wb_cyc_o, 1'b0);
    @(negedge clk);
    if (w) exp_err = 0;
    check("stat_ack", ack_o, 1'b1);
    check("stat_no_cyc2", wb_cyc_o, 1'b0);
    check("stat_err", err_count_o, exp_err);
    en_i = 0;
    @(negedge clk);
    check("stat_pulse", ack_o, 1'b0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", ack_o, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_sel", wb_sel_o, 4'h0);
    check("rst_adr", wb_adr_o, 20'h0);
    check("rst_err", err_count_o, 8'h0);
    rst = 0;
    @(negedge clk);
    txn(0, 20'h00010, 4'h0, 32'h0, 3, 0, 32'h12345678, 0);
    txn(1, 20'h00004, 4'b0110, 32'hA5A5A5A5, 0, 0, 32'hFFFFFFFF, 0);
    txn(0, 20'h00020, 4'h0, 32'h0, 0, 3, 32'h0, 0);
    txn(1, 20'h00030, 4'b1001, 32'h0BADF00D, 1, 1, 32'h0, 0);
    txn(0, 20'h00040, 4'h0, 32'h0, 2, 2, 32'h55AA55AA, 0);
    txn(0, 20'h00050, 4'h0, 32'h0, TMO - 1, 0, 32'hCAFEF00D, 0);
    txn(0, 20'h00060, 4'h0, 32'h0, 4, 0, 32'h0F0F0F0F, 1);
    // stray slave responses while idle must not produce an ack
    wb_ack_i = 1; wb_err_i = 1;
    @(negedge clk);
    wb_ack_i = 0; wb_err_i = 0;
    @(negedge clk);
    check("idle_resp_ignored", ack_o, 1'b0);
    check("idle_err_unchanged", err_count_o, exp_err);
    // reset two cycles into a bus cycle
    en_i = 1; wr_i = 0; adr_i = 20'h00070;
    repeat (2) @(negedge clk);
    rst = 1; #1;
    check("rst_mid_cyc", wb_cyc_o, 1'b0);
    check("rst_mid_stb", wb_stb_o, 1'b0);
    exp_err = 0;
    @(negedge clk);
    rst = 0; en_i = 0;
    repeat (5) @(negedge clk);
    check("rst_no_ack", ack_o, 1'b0);
    txn(0, 20'h00080, 4'h0, 32'h0, 1, 0, 32'hDEADBEEF, 0);
`ifdef BM_BRIDGE_STATUS_EN
    repeat (3) txn(1, 20'h00090, 4'hF, 32'h1, 0, 1, 32'h0, 0);
    stat(0);
    stat(1);
`else
    txn(0, 20'hFFFFF, 4'h0, 32'h0, 1, 0, 32'h13572468, 0);
`endif
    for (int i = 0; i < 258; i++) txn(1, 20'(i), 4'hF, 32'(i), 0, 1, 32'h0, 0);
    check("err_saturated", err_count_o, 8'hFF);
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/bm_bus_bridge.md
BM_BUS_BRIDGE -- requirements
Module: bm_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_BITS, default 8: width of the bus-timeout counter.
REQ-002 Parameter TIMEOUT_CYCLES, default 200: wb cycles waited before abort; SHALL be <= 2^TIMEOUT_BITS-1.
REQ-003 clk  in  1: single clock; all logic on its rising edge.
REQ-004 rst  in  1: reset, asynchronous, active-high.
REQ-005 en_i  in  1: board-manager request, level, held until ack_o.
REQ-006 wr_i  in  1: 1 = write, 0 = read; valid while en_i.
REQ-007 adr_i  in  20: 32-bit-word address.
REQ-008 wstrb_i  in  4: byte write strobes.
REQ-009 dat_i  in  32: write data.
REQ-010 ack_o  out  1: one-cycle completion pulse.
REQ-011 dat_o  out  32: read data, valid while ack_o.
REQ-012 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each: Wishbone-classic master controls.
REQ-013 wb_adr_o  out  20; wb_sel_o  out  4; wb_dat_o  out  32: registered copies of adr_i, wstrb_i (reads: 4'hF), dat_i.
REQ-014 wb_dat_i  in  32; wb_ack_i  in  1; wb_err_i  in  1: slave responses.
REQ-015 err_count_o  out  8: saturating count of aborted transactions.

Function
REQ-016 FSM states: IDLE, BUS, ACK; 2-bit encoding.
REQ-017 IDLE with en_i=1 at cycle 0: latch adr/wr/wstrb/dat, clear timer, enter BUS; wb_cyc_o=wb_stb_o=1 from cycle 1.
REQ-018 BUS: cyc/stb held high and wb_adr/sel/dat/we stable until termination.
REQ-019 Termination on wb_ack_i at cycle k: enter ACK; ack_o=1 at cycle k+1; dat_o=wb_dat_i captured at k (reads); cyc/stb=0 at k+1.
REQ-020 Termination on wb_err_i, or timer reaching TIMEOUT_CYCLES: same as REQ-019, but dat_o=BM_ERR_DATA (32'hBADACCE5) and err_count_o increments.
REQ-021 wb_ack_i and wb_err_i together: treated as error.
REQ-022 wb_ack_i in the same cycle as timeout expiry: treated as success.
REQ-023 err_count_o saturates at 8'hFF.
REQ-024 ACK lasts exactly one cycle, then IDLE; en_i is ignored during ACK. Minimum request-to-request spacing is therefore 3 cycles.
REQ-025 en_i dropping while in BUS: no effect; the transaction completes and ack_o is still pulsed.
REQ-026 wb_ack_i/wb_err_i while not in BUS: ignored.
REQ-027 Writes: dat_o=32'h0 with ack_o unless REQ-020 applies.

Reset
REQ-028 rst=1 forces IDLE immediately. Outputs go to 0: ack_o, wb_cyc_o, wb_stb_o, wb_we_o, dat_o, wb_adr_o, wb_sel_o, wb_dat_o, err_count_o, timer.
REQ-029 rst asserted mid-BUS: cyc/stb drop asynchronously; no ack_o is generated after release.

Configuration
REQ-030 Macro BM_BRIDGE_STATUS_EN defined: adr_i == 20'hFFFFF is served locally with no Wishbone cycle. Reads return {16'h0, 8'(TIMEOUT_CYCLES), err_count_o} with ack_o at cycle 2. Writes clear err_count_o, ack_o at cycle 2.
REQ-031 Macro undefined: 20'hFFFFF is forwarded like any other address; no local decode logic is present.

Structure
REQ-032 Package bm_bridge_pkg: state typedef, BM_ERR_DATA, BM_STATUS_ADDR (20'hFFFFF).
REQ-033 Flat module, no sub-modules; timer and error counter inline.

Verification
REQ-034 Read adr_i=20'h00010, slave acks 3 cycles after stb with 32'h12345678 -> one ack_o pulse, dat_o=32'h12345678, wb_sel_o=4'hF, wb_we_o=0.
REQ-035 Write adr_i=20'h00004, wstrb_i=4'b0110, dat_i=32'hA5A5A5A5, zero-wait ack -> wb_we_o=1, wb_sel_o=4'b0110, ack_o one cycle after wb_ack_i, dat_o=0.
REQ-036 Read, slave never responds -> cyc drops and ack_o=1 after TIMEOUT_CYCLES (200), dat_o=32'hBADACCE5, err_count_o=1.
REQ-037 wb_err_i on a write -> ack_o pulse, err_count_o increments; 256 errors -> err_count_o stays 8'hFF.
REQ-038 rst pulsed 2 cycles into BUS -> cyc/stb low same cycle, no ack_o; next request completes normally.
REQ-039 With BM_BRIDGE_STATUS_EN: read 20'hFFFFF after 3 errors -> dat_o=32'h0000C803, no wb_cyc_o; write it -> err_count_o=0.
